// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync
// generator and downstream pixel-generation logic.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL =
    H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL =
    V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START = H_VISIBLE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_VISIBLE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  function automatic logic in_span(
    input logic [CNT_W-1:0] val,
    input logic [CNT_W-1:0] lo,
    input logic [CNT_W-1:0] hi
  );
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-N counter with enable; o_wrap flags the enabled
// edge that rolls N-1 over to 0, so counters can be chained.
module vga_counter
  import vga_timing_pkg::*;
#(
  parameter int N = H_TOTAL,
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LP_LAST = W'(N - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LP_LAST);
  assign o_wrap = i_en & w_last;
  assign o_cnt  = r_cnt;

  // Next value, exposed so the parent can decode ahead of the edge
  always_comb begin
    o_nxt = r_cnt;
    if (i_en) o_nxt = w_last ? '0 : r_cnt + W'(1);
  end

  // Reset parks on N-1 so the first enabled edge lands on 0
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= LP_LAST;
    else     r_cnt <= o_nxt;
  end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: chained h/v counters with sync, video
// and line/frame strobes registered on the same edge as x/y.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int LP_HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int LP_VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] LP_H_VIS =
    CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] LP_V_VIS =
    CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] LP_HS_LO =
    CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] LP_HS_HI =
    CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] LP_VS_LO =
    CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] LP_VS_HI =
    CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] w_h, w_h_nxt;
  logic [CNT_W-1:0] w_v, w_v_nxt;
  logic             w_h_wrap, w_v_wrap;

  logic r_hsync, r_vsync, r_video, r_line, r_frame;

  vga_counter #(.N(LP_HT), .W(CNT_W)) u_hcnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (pix_en),
    .o_cnt  (w_h),
    .o_nxt  (w_h_nxt),
    .o_wrap (w_h_wrap)
  );

  vga_counter #(.N(LP_VT), .W(CNT_W)) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_h_wrap),
    .o_cnt  (w_v),
    .o_nxt  (w_v_nxt),
    .o_wrap (w_v_wrap)
  );

  // Decode from next counter values so flags align with x/y
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_video <= 1'b0;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_hsync <= !in_span(w_h_nxt, LP_HS_LO, LP_HS_HI);
      r_vsync <= !in_span(w_v_nxt, LP_VS_LO, LP_VS_HI);
      r_video <= (w_h_nxt < LP_H_VIS) && (w_v_nxt < LP_V_VIS);
      r_line  <= w_h_wrap;
      r_frame <= w_v_wrap;
    end
  end

  assign x           = w_h;
  assign y           = w_v;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video;
  assign line_start  = r_line;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default 640x480 instance for
// line-level timing, shrunken instance for frame-level timing.
module tb_vga_sync;

  logic clk;
  logic ra, pa, rb, pb;

  logic       hs_a, vs_a, vid_a, ln_a, fr_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, vid_b, ln_b, fr_b;
  logic [9:0] x_b, y_b;

  int total = 0;
  int bad   = 0;

  int ax, ay, bx, by;
  int hlow, vlow, n;

  vga_sync u_a (
    .clk         (clk),
    .rst         (ra),
    .pix_en      (pa),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .video_on    (vid_a),
    .x           (x_a),
    .y           (y_a),
    .line_start  (ln_a),
    .frame_start (fr_a)
  );

  // H: 8+2+3+2=15, V: 6+1+2+2=11, frame = 165 cycles
  vga_sync #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_b (
    .clk         (clk),
    .rst         (rb),
    .pix_en      (pb),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .video_on    (vid_b),
    .x           (x_b),
    .y           (y_b),
    .line_start  (ln_b),
    .frame_start (fr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mdl(inout int mx, inout int my, input bit en,
                     input int ht, input int vt,
                     output bit ln, output bit fr);
    ln = 0;
    fr = 0;
    if (en) begin
      if (mx == ht - 1) begin
        mx = 0;
        ln = 1;
        if (my == vt - 1) begin
          my = 0;
          fr = 1;
        end else my++;
      end else mx++;
    end
  endtask

  task automatic cyc_a(bit en, bit r);
    bit eln, efr;
    pa = en;
    ra = r;
    @(posedge clk);
    #1;
    if (r) begin
      ax = 799; ay = 524; eln = 0; efr = 0;
    end else mdl(ax, ay, en, 800, 525, eln, efr);
    chk("a_x", x_a, ax);
    chk("a_y", y_a, ay);
    chk("a_hsync", hs_a, !(ax >= 656 && ax <= 751));
    chk("a_vsync", vs_a, !(ay >= 490 && ay <= 491));
    chk("a_video", vid_a, (ax < 640 && ay < 480));
    chk("a_line", ln_a, eln);
    chk("a_frame", fr_a, efr);
    chk("a_range", (x_a < 800 && y_a < 525), 1);
  endtask

  task automatic cyc_b(bit en, bit r);
    bit eln, efr;
    pb = en;
    rb = r;
    @(posedge clk);
    #1;
    if (r) begin
      bx = 14; by = 10; eln = 0; efr = 0;
    end else mdl(bx, by, en, 15, 11, eln, efr);
    chk("b_x", x_b, bx);
    chk("b_y", y_b, by);
    chk("b_hsync", hs_b, !(bx >= 10 && bx <= 12));
    chk("b_vsync", vs_b, !(by >= 7 && by <= 8));
    chk("b_video", vid_b, (bx < 8 && by < 6));
    chk("b_line", ln_b, eln);
    chk("b_frame", fr_b, efr);
    chk("b_range", (x_b < 15 && y_b < 11), 1);
  endtask

  initial begin
    ra = 1; pa = 0; rb = 1; pb = 0;
    ax = 0; ay = 0; bx = 0; by = 0;

    // reset both instances; B then idles
    cyc_b(0, 1);
    cyc_b(0, 1);
    rb = 0;
    cyc_a(0, 1);
    cyc_a(0, 1);

    // first enabled edge lands on (0,0) with both strobes
    cyc_a(1, 0);
    chk("a_first_frame", fr_a, 1);

    // pix_en low: everything holds, strobes drop
    repeat (3) cyc_a(0, 0);

    // continuous run across line 0 up to x=797
    hlow = 0;
    repeat (797) begin
      cyc_a(1, 0);
      if (!hs_a) hlow++;
      if (x_a == 10'd639) chk("a_vid_639", vid_a, 1);
      if (x_a == 10'd640) chk("a_vid_640", vid_a, 0);
    end
    chk("a_hsync_width", hlow, 96);

    // divide-by-4 strobe across the line wrap
    for (int k = 0; k < 12; k++) cyc_a(k % 4 == 0, 0);
    chk("a_div_y", y_a, 1);

    // mid-line reset inside hsync, pix_en held high
    repeat (700) cyc_a(1, 0);
    chk("a_pre_rst_hs", hs_a, 0);
    cyc_a(1, 1);
    cyc_a(0, 0);
    cyc_a(1, 0);
    chk("a_post_rst_frame", fr_a, 1);
    pa = 0;

    // B: full frame period and vsync width
    cyc_b(1, 0);
    chk("b_first_frame", fr_b, 1);
    n = 0;
    vlow = 0;
    for (int i = 0; i < 200; i++) begin
      cyc_b(1, 0);
      n++;
      if (!vs_b) vlow++;
      if (fr_b) break;
    end
    chk("b_frame_period", n, 165);
    chk("b_vsync_cycles", vlow, 30);

    // B: reset while both syncs are low (x=11, y=7)
    repeat (116) cyc_b(1, 0);
    chk("b_pre_rst_hs", hs_b, 0);
    chk("b_pre_rst_vs", vs_b, 0);
    cyc_b(1, 1);
    cyc_b(1, 0);
    chk("b_post_rst_frame", fr_b, 1);
    chk("b_post_rst_line", ln_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
